// File: rtl/rom_feeder_pkg.sv
// rom_feeder_pkg: shared state encoding and default sizing for the ROM feeder.
package rom_feeder_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RDY, START, WAIT_DONE} feeder_state_t;
  localparam int N_DEF = 32;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 8;
  localparam int TIMEOUT_DEF = 1024;
endpackage

// File: rtl/feeder_fetch.sv
// feeder_fetch: fetch index counter, wrapping ROM address and buffer write decode.
module feeder_fetch #(
  parameter int N = 32,
  parameter int AW = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  run,
  input  logic [AW-1:0]         base,
  output logic [AW-1:0]         addr,
  output logic                  wr_en,
  output logic [$clog2(N)-1:0]  wr_idx,
  output logic                  last
);
  localparam int IW = $clog2(N) + 1;
  localparam int PW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N);
  logic [IW-1:0] idx;
  // Data lags the address by one cycle, so cycle k writes slot k-1.
  assign wr_en = run && idx != '0;
  assign wr_idx = PW'(idx - IW'(1));
  assign last = run && idx == LAST_IDX;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      idx <= '0;
      addr <= '0;
    end else if (start) begin
      idx <= '0;
      addr <= base;
    end else if (run && !last) begin
      idx <= idx + IW'(1);
      if (idx + IW'(1) < LAST_IDX) addr <= addr + AW'(1);
    end
endmodule

// File: rtl/rom_feeder.sv
// rom_feeder: reads N ROM bytes into a held array, starts the engine, captures its mean.
// Optional WAIT_DONE watchdog with sticky timeout_err when ROM_FEEDER_TIMEOUT_EN is defined.
module rom_feeder
  import rom_feeder_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [AW-1:0] base,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] rom_out [N],
  output logic          eng_start,
  input  logic          eng_ready,
  input  logic          eng_done,
  input  logic [DW-1:0] eng_mean,
  output logic [DW-1:0] mean_out,
  output logic          mean_valid,
  output logic          busy
`ifdef ROM_FEEDER_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);
  localparam int PW = $clog2(N);
  feeder_state_t state, next;
  logic take, run, last, wr_en, expire, finish;
  logic [PW-1:0] wr_idx;
  assign take = state == IDLE && go;
  assign run = state == FETCH;
  assign finish = state == WAIT_DONE && eng_done;
  assign eng_start = state == START;
  assign busy = state != IDLE;
  feeder_fetch #(.N(N), .AW(AW)) u_fetch (
    .clk(clk),
    .rst(rst),
    .start(take),
    .run(run),
    .base(base),
    .addr(rom_addr),
    .wr_en(wr_en),
    .wr_idx(wr_idx),
    .last(last)
  );
`ifdef ROM_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign expire = state == WAIT_DONE && !eng_done && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tcnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      tcnt <= state == WAIT_DONE ? tcnt + TW'(1) : '0;
      if (expire) timeout_err <= 1'b1;
    end
`else
  assign expire = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = go ? FETCH : IDLE;
      FETCH:     next = !last ? FETCH : eng_ready ? START : WAIT_RDY;
      WAIT_RDY:  next = eng_ready ? START : WAIT_RDY;
      START:     next = WAIT_DONE;
      WAIT_DONE: next = eng_done || expire ? IDLE : WAIT_DONE;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int j = 0; j < N; j++) rom_out[j] <= '0;
      mean_out <= '0;
      mean_valid <= 1'b0;
    end else begin
      if (wr_en) rom_out[wr_idx] <= rom_data;
      mean_valid <= finish;
      if (finish) mean_out <= eng_mean;
    end
endmodule

// File: tb/tb_rom_feeder.sv
// tb_rom_feeder: directed vectors plus corner sequences for rom_feeder.
module tb_rom_feeder;
  localparam int N = 32;
  typedef struct {
    logic [7:0] base;
    int pat;
    int dly;
    logic [7:0] val;
    logic [7:0] o0, o16, o31;
    int st_c;
    int mv_c;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, go = 1'b0;
  logic [7:0] base = '0, rom_addr, rom_data = '0, eng_mean, mean_out;
  logic [7:0] rom_out [N];
  logic eng_start, eng_ready = 1'b1, eng_done, mean_valid, busy;
  logic auto_eng = 1'b1, force_done = 1'b0;
  logic [7:0] eng_val = '0;
  logic [7:0] rom_mem [256];
  int eng_cnt = 0;
  int n_chk = 0, n_fail = 0;
  vec_t vec [4];
`ifdef ROM_FEEDER_TIMEOUT_EN
  logic timeout_err;
`endif
  rom_feeder #(.N(N), .DW(8), .AW(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .go(go), .base(base), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_out(rom_out), .eng_start(eng_start),
    .eng_ready(eng_ready), .eng_done(eng_done), .eng_mean(eng_mean),
    .mean_out(mean_out), .mean_valid(mean_valid), .busy(busy)
`ifdef ROM_FEEDER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];
  // Engine model: done one cycle, three cycles after it sees start.
  always @(posedge clk)
    if (!rst) eng_cnt <= 0;
    else if (eng_start && auto_eng) eng_cnt <= 3;
    else if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
  assign eng_done = force_done || eng_cnt == 1;
  assign eng_mean = eng_val;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_rom(input int pat);
    for (int a = 0; a < 256; a++)
      rom_mem[a] = pat == 0 ? 8'd10 : pat == 1 ? 8'(a) : 8'(255 - a);
  endtask

  task automatic launch(input logic [7:0] b);
    @(negedge clk);
    go = 1'b1;
    base = b;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int st_c = 0, n_st = 0, n_mv = 0, mv_c = 0, addr_bad = 0, busy_mv = 1;
    logic [7:0] mv_mean = '0;
    fill_rom(v.pat);
    eng_val = v.val;
    auto_eng = 1'b1;
    force_done = 1'b0;
    eng_ready = v.dly == 0;
    launch(v.base);
    check("busy_e0", busy, 1);
    check("addr_e0", rom_addr, v.base);
    for (int c = 1; c <= N + v.dly + 12; c++) begin
      @(posedge clk);
      #1;
      if (rom_addr != (c < N ? 8'(v.base + c) : 8'(v.base + N - 1))) addr_bad++;
      eng_ready = c >= N + v.dly || (v.dly == 0 && (c < 10 || c >= 20));
      if (eng_start) begin
        n_st++;
        if (st_c == 0) st_c = c;
      end
      if (mean_valid) begin
        n_mv++;
        mv_c = c;
        mv_mean = mean_out;
        busy_mv = busy;
      end
    end
    check("addr_seq_errors", addr_bad, 0);
    check("start_cycle", st_c, v.st_c);
    check("start_count", n_st, 1);
    check("mv_count", n_mv, 1);
    check("mv_cycle", mv_c, v.mv_c);
    check("mean_out", mv_mean, v.val);
    check("busy_at_mv", busy_mv, 0);
    check("rom_out0", rom_out[0], v.o0);
    check("rom_out16", rom_out[16], v.o16);
    check("rom_out31", rom_out[31], v.o31);
  endtask

  initial begin
    int n_st, n_mv, mv_c, nz;
    vec[0] = '{8'd0,   0, 0, 8'd10,  8'd10,  8'd10,  8'd10,  33, 37};
    vec[1] = '{8'd240, 1, 0, 8'd77,  8'd240, 8'd0,   8'd15,  33, 37};
    vec[2] = '{8'd100, 2, 5, 8'd200, 8'd155, 8'd139, 8'd124, 38, 42};
    vec[3] = '{8'd0,   1, 0, 8'd0,   8'd0,   8'd16,  8'd31,  33, 37};
    #2;
    check("rst_busy", busy, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_start", eng_start, 0);
    check("rst_mv", mean_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(vec[i]);
    // Spurious go and done pulses outside IDLE/WAIT_DONE must be ignored.
    fill_rom(0);
    eng_val = 8'd55;
    auto_eng = 1'b0;
    eng_ready = 1'b1;
    launch(8'd0);
    n_st = 0;
    n_mv = 0;
    mv_c = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1;
      go = c == 5 || c == 36;
      force_done = c == 5 || c == 33 || c == 39;
      if (eng_start) n_st++;
      if (mean_valid) begin
        n_mv++;
        mv_c = c;
      end
    end
    check("ign_starts", n_st, 1);
    check("ign_mv_count", n_mv, 1);
    check("ign_mv_cycle", mv_c, 40);
    check("ign_mean", mean_out, 55);
    check("ign_busy_end", busy, 0);
    // Reset in fetch cycle 12 aborts and clears everything.
    fill_rom(1);
    eng_val = 8'd9;
    auto_eng = 1'b1;
    launch(8'd50);
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    nz = 0;
    for (int k = 0; k < N; k++) if (rom_out[k] != 8'd0) nz++;
    check("mid_rst_rom_out_nonzero", nz, 0);
    check("mid_rst_addr", rom_addr, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_start", eng_start, 0);
    check("mid_rst_mean", mean_out, 0);
    check("mid_rst_mv", mean_valid, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_vec(vec[0]);
`ifdef ROM_FEEDER_TIMEOUT_EN
    fill_rom(0);
    auto_eng = 1'b0;
    eng_ready = 1'b1;
    launch(8'd0);
    n_mv = 0;
    for (int c = 1; c <= 52; c++) begin
      @(posedge clk);
      #1;
      if (mean_valid) n_mv++;
      if (c == 49) begin
        check("to_err_early", timeout_err, 0);
        check("to_busy_early", busy, 1);
      end
      if (c == 50) begin
        check("to_err", timeout_err, 1);
        check("to_busy", busy, 0);
      end
    end
    check("to_mv_count", n_mv, 0);
    check("to_err_sticky", timeout_err, 1);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_feeder.md
# rom_feeder

Front-end sequencer for the two-half mean engine (32 × 8-bit input array; `start`, `ready`, `done`, `mean`). It reads N bytes from a synchronous ROM starting at a caller-supplied base address and assembles them into a held parallel array. When the engine reports ready it issues a one-cycle start, then captures the engine's mean on done. It sits between the ROM macro and the engine and is the only block that drives the engine's start and data inputs.

## Interface
- `N`, 32 — bytes per block; equals engine array length; power of two ≥ 2
- `DW`, 8 — data width
- `AW`, 8 — ROM address width
- `TIMEOUT`, 1024 — max WAIT_DONE cycles (used only with the macro in Configuration)
- `clk`  in  1  — single clock, rising edge
- `rst`  in  1  — asynchronous, active-low reset
- `go`  in  1  — request one block; sampled in IDLE only
- `base`  in  AW  — first ROM address; latched when `go` is accepted
- `rom_addr`  out  AW  — ROM address
- `rom_data`  in  DW  — ROM read data, valid one cycle after address
- `rom_out`  out  DW × [0:N-1]  — assembled block to engine
- `eng_start`  out  1  — start pulse to engine
- `eng_ready`  in  1  — engine idle/ready
- `eng_done`  in  1  — engine result valid
- `eng_mean`  in  DW  — engine result
- `mean_out`  out  DW  — captured mean
- `mean_valid`  out  1  — one-cycle pulse when `mean_out` updates
- `busy`  out  1  — high in every state except IDLE
- `timeout_err`  out  1  — sticky error; present only with the macro

## Operation
- States: IDLE, FETCH, WAIT_RDY, START, WAIT_DONE.
- IDLE: `go`=1 latches `base`, clears index `i`, goes to FETCH. `go` in any other state is ignored.
- FETCH: lasts N+1 cycles.
  - In fetch cycle k (0..N-1), drive `rom_addr` = base+k, modulo 2^AW. Addresses wrap past 2^AW−1 to 0 with no error.
  - In fetch cycle k+1, write `rom_data` into `rom_out[k]`.
  - After `rom_out[N-1]` is written: go to START if `eng_ready`=1 that cycle, else to WAIT_RDY.
- WAIT_RDY: stay until `eng_ready`=1, then go to START.
- START: `eng_start`=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: on `eng_done`=1, set `mean_out` ← `eng_mean` and pulse `mean_valid`, then return to IDLE.
  - `eng_done` is ignored in every other state, including the START cycle itself.
- `rom_out` changes only during FETCH. It is held stable from the last write until the next accepted `go`.
- `rom_addr` holds its last value outside FETCH.
- No arithmetic on data. The address adder is AW bits and truncating; the index counter is clog2(N)+1 bits.

## Timing
- Reset (async assert, sync release), all outputs 0: `rom_addr`, `rom_out`, `eng_start`, `mean_out`, `mean_valid`, `busy`, `timeout_err`. State goes to IDLE.
- Reset mid-operation aborts immediately. Any in-flight engine result is dropped.
- `go` accepted at edge E0 → `busy`=1 from E0. First `rom_addr` = base during cycle E0..E0+1.
- With `eng_ready` steady high, `eng_start` is high in cycle E0+N+1..E0+N+2.
- `eng_done` sampled at edge Ed → `mean_valid`=1 for cycle Ed..Ed+1, and `busy`=0 from Ed.
- Back-to-back operation: the earliest next `go` acceptance is edge Ed+1.
- `eng_ready` dropping during FETCH has no effect. Only its value at the end of FETCH or in WAIT_RDY matters.

## Configuration
- `ROM_FEEDER_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT_DONE.
  - If `TIMEOUT` cycles elapse without `eng_done`, set `timeout_err`=1 (sticky until reset) and return to IDLE without pulsing `mean_valid`.
- Undefined: no counter and no `timeout_err` port. WAIT_DONE waits indefinitely.

## Structure
- Package `rom_feeder_pkg`: state enum `feeder_state_t`; default constants for N, DW, AW and TIMEOUT.
- One sub-module, `feeder_fetch`: index counter, address adder and buffer write-enable decode, with a start input and a last output. The FSM stays in `rom_feeder`.

## Test plan
- ROM all 8'd10, base=0, engine model returns 10 with 3-cycle latency, ready high → addresses 0..31 in order; `eng_start` at E0+33; `mean_out`=10; `mean_valid` for one cycle.
- ROM[i]=i, base=8'd240 → addresses 240..255 then 0..15; `rom_out[0]`=240, `rom_out[16]`=0.
- `eng_ready` low for 5 cycles after FETCH → state stays WAIT_RDY; `eng_start` appears the cycle after `eng_ready` rises; `rom_out` unchanged throughout.
- `go` pulsed during FETCH and WAIT_DONE, and `eng_done` forced high in FETCH and START → all ignored; exactly one `mean_valid`.
- `rst` low for 1 cycle mid-FETCH (k=12) → all outputs 0, state IDLE; a new `go` completes normally.
- With `ROM_FEEDER_TIMEOUT_EN` and TIMEOUT=16, engine never asserts done → `timeout_err`=1 after 16 WAIT_DONE cycles, `busy`=0, no `mean_valid`.
